// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state codes, the write R/W bit value and a
// helper that picks the state following an ACK slot.
`timescale 1ns/1ps
package i2c_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_REG      = 3'd3;
    localparam logic [2:0] ST_REG_ACK  = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_DATA_ACK = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        ADDR     = ST_ADDR,
        ADDR_ACK = ST_ADDR_ACK,
        REG      = ST_REG,
        REG_ACK  = ST_REG_ACK,
        DATA     = ST_DATA,
        DATA_ACK = ST_DATA_ACK,
        IGNORE   = ST_IGNORE
    } i2c_slv_state_t;

    localparam logic I2C_WRITE = 1'b0;

    // After the address ACK comes the register byte; every later ACK leads to data.
    function automatic logic [2:0] ack_next_state(input logic [2:0] s);
        return (s == ST_ADDR_ACK) ? ST_REG : ST_DATA;
    endfunction

endpackage

// File: rtl/i2c_slave_regfile.sv
// NUM_REGS x 8 register file: synchronous write, combinational read,
// synchronous active-low clear of every entry.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [REG_AW-1:0] raddr,
    output logic [7:0]        rdata
);
    localparam int NUM_REGS = 2 ** REG_AW;

    logic [7:0] mem_q [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!clr_n) begin
                mem_q[gi] <= 8'h00;
            end else if (we && (waddr == REG_AW'(gi))) begin
                mem_q[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/i2c_slave_write.sv
// I2C write-only slave: oversamples scl/sda, decodes START/STOP, ACKs address,
// register and data bytes, and stores data at an auto-incrementing pointer.
`timescale 1ns/1ps
module i2c_slave_write
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         REG_AW      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    inout  wire               sda,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det;

    logic [2:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_valid_q, wr_valid_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        byte_next;
    logic              reg_we;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign sda_rise  =  sda_s & ~sda_prev_q;
    assign sda_fall  = ~sda_s &  sda_prev_q;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign byte_next = {shift_q[6:0], sda_s};

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        reg_we     = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (byte_next[7:1] == SLAVE_ADDR && byte_next[0] == I2C_WRITE) begin
                                    state_d = ST_ADDR_ACK;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_REG) begin
                                ptr_d   = byte_next[REG_AW-1:0];
                                state_d = ST_REG_ACK;
                            end else begin
                                reg_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_next;
                                ptr_d      = ptr_q + REG_AW'(1);
                                state_d    = ST_DATA_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                    // First falling edge opens the ACK slot, the second one closes it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ack_next_state(state_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    i2c_slave_regfile #(
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk   (clk),
        .clr_n (reset),
        .we    (reg_we),
        .waddr (ptr_q),
        .wdata (byte_next),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_write.sv
// Bench for i2c_slave_write: a bit-banged master drives directed and random
// write transactions; a transaction-level model predicts writes and ACKs.
`timescale 1ns/1ps
module tb_i2c_slave_write;
    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_oe = 1'b0;
    wire        sda;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [7:0]  m_regs [16];
    logic [3:0]  m_ptr = 4'd0;
    logic [11:0] exp_q [$];
    logic [7:0]  tx_bytes [$];
    logic [11:0] mon_e;

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_write #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2),
        .REG_AW      (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_valid cycle must match the oldest predicted write.
    always @(negedge clk) begin
        if (wr_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), int'(mon_e[11:8]));
                check("wr_data", int'(wr_data), int'(mon_e[7:0]));
                $display("write reg[%0d] = 0x%02h", wr_addr, wr_data);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output bit bad);
        m_sda_oe = ~b;
        hq();
        scl = 1'b1;
        hq();
        bad = (sda !== b);
        hq();
        scl = 1'b0;
        hq();
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ack);
        bit bad;
        bit bad_any;
        bad_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], bad);
            bad_any |= bad;
        end
        check("bus_drive", int'(bad_any), 0);
        m_sda_oe = 1'b0;
        hq();
        scl = 1'b1;
        hq();
        ack = (sda === 1'b0);
        hq();
        scl = 1'b0;
        hq();
    endtask

    task automatic i2c_start();
        if (scl == 1'b0) begin
            m_sda_oe = 1'b0;
            hq();
            scl = 1'b1;
            hq();
        end
        m_sda_oe = 1'b1;
        hq();
        scl = 1'b0;
        hq();
    endtask

    task automatic i2c_stop();
        m_sda_oe = 1'b1;
        hq();
        scl = 1'b1;
        hq();
        m_sda_oe = 1'b0;
        hq();
        hq();
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("rd[%0d]", i), int'(rd_data), int'(m_regs[i]));
        end
    endtask

    // One transaction: address, then (if addressed) register byte, all queued data
    // bytes and an optional partial byte, then STOP.
    task automatic xact(input logic [6:0] a7, input logic rw, input logic [7:0] ra, input int partial);
        bit         ack;
        bit         exp_ack;
        bit         bad;
        logic [7:0] d;
        i2c_start();
        exp_ack = (a7 == 7'h50) && (rw == 1'b0);
        send_byte({a7, rw}, ack);
        check("addr_ack", int'(ack), int'(exp_ack));
        check("busy_addr", int'(busy), int'(exp_ack));
        if (exp_ack) begin
            send_byte(ra, ack);
            check("reg_ack", int'(ack), 1);
            m_ptr = ra[3:0];
            while (tx_bytes.size() > 0) begin
                d = tx_bytes.pop_front();
                exp_q.push_back({m_ptr, d});
                m_regs[m_ptr] = d;
                m_ptr = m_ptr + 4'd1;
                send_byte(d, ack);
                check("data_ack", int'(ack), 1);
            end
            for (int i = 0; i < partial; i++) begin
                send_bit(1'($urandom_range(0, 1)), bad);
                check("bus_partial", int'(bad), 0);
            end
        end else begin
            tx_bytes.delete();
            send_byte(8'($urandom), ack);
            check("ignore_ack", int'(ack), 0);
            check("busy_ignore", int'(busy), 0);
        end
        i2c_stop();
        check("busy_idle", int'(busy), 0);
        $display("xact addr=0x%02h rw=%0d reg=0x%02h partial=%0d done", a7, rw, ra, partial);
    endtask

    initial begin
        bit ack;
        bit bad;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

        repeat (4) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_valid", int'(wr_valid), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_sda", int'(sda === 1'b1), 1);
        sweep();
        reset = 1'b1;
        repeat (4) @(negedge clk);

        tx_bytes = '{8'hA5};
        xact(7'h50, 1'b0, 8'h03, 0);
        sweep();

        tx_bytes = '{8'h11, 8'h22, 8'h33};
        xact(7'h50, 1'b0, 8'h0E, 0);
        sweep();

        xact(7'h51, 1'b0, 8'h00, 0);
        xact(7'h50, 1'b1, 8'h00, 0);

        i2c_start();
        send_byte(8'hA0, ack);
        check("rs_addr_ack", int'(ack), 1);
        send_byte(8'h05, ack);
        check("rs_reg_ack", int'(ack), 1);
        tx_bytes = '{8'h5A};
        xact(7'h50, 1'b0, 8'h07, 0);
        sweep();

        xact(7'h50, 1'b0, 8'h03, 4);
        sweep();
        tx_bytes = '{8'h77};
        xact(7'h50, 1'b0, 8'h03, 0);
        sweep();

        // Reset while the slave holds the register-byte ACK low.
        i2c_start();
        send_byte(8'hA0, ack);
        check("rstx_addr_ack", int'(ack), 1);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h09 >> i), bad);
        m_sda_oe = 1'b0;
        hq();
        check("rstx_ack_drive", int'(sda === 1'b0), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rstx_sda_rel", int'(sda === 1'b1), 1);
        check("rstx_wr_valid", int'(wr_valid), 0);
        check("rstx_busy", int'(busy), 0);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        sweep();
        i2c_stop();
        tx_bytes = '{8'hC3, 8'h3C};
        xact(7'h50, 1'b0, 8'h09, 0);
        sweep();

        for (int t = 0; t < 16; t++) begin
            logic [6:0] a7;
            logic       rw;
            int         nd;
            int         part;
            a7   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
            rw   = ($urandom_range(0, 4) == 0);
            nd   = $urandom_range(1, 4);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            for (int k = 0; k < nd; k++) tx_bytes.push_back(8'($urandom));
            xact(a7, rw, 8'($urandom), part);
        end
        sweep();

        repeat (10) @(negedge clk);
        check("wr_missing", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_write.md
Name: i2c_slave_write

Overview:
- I2C slave target for the master write path: receives START, 7-bit address + R/W, register-address byte, then one or more data bytes, and ACKs each byte.
- Received data is written into an internal register file with an auto-incrementing pointer. Each write is also reported on a one-cycle write strobe.
- Sits directly on the sda/scl bus downstream of the I2C master, and is the consumer of its start/address/reg/data/stop sequence.
- SCL and SDA are oversampled on the system clock; the block never drives SCL.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop depth of the scl/sda input synchronisers (minimum 2).
- REG_AW, 4, register-file address width; NUM_REGS = 2**REG_AW.

Ports:
- clk  input  1  system clock; at least 8x the SCL frequency.
- reset  input  1  synchronous, active-low reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data; the block drives only 0, otherwise z.
- rd_addr  input  REG_AW  register-file read address (host/debug side).
- rd_data  output  8  combinational read of regfile[rd_addr].
- wr_valid  output  1  one-clk pulse when a data byte is written.
- wr_addr  output  REG_AW  register index written; valid with wr_valid.
- wr_data  output  8  byte written; valid with wr_valid.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - state=IDLE, sda released (z), wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - Bit counter=0, pointer=0, all registers=8'h00.
  - Synchronisers are preset to 1.
  - This applies identically mid-transfer: the bus is released within one clk.
- Edge detection: scl_s/sda_s are synchronised copies; the registered previous values give scl_rise, scl_fall, sda_rise and sda_fall (each one clk wide).
- START = sda_fall while scl_s==1. STOP = sda_rise while scl_s==1. Both have priority over everything else.
  - START in any state, including a repeated START: go to ADDR, bit counter=0, release sda.
  - STOP in any state: go to IDLE, release sda, busy=0.
- Data bits are sampled on scl_rise, MSB first, into an 8-bit shift register. The bit counter runs 0..7.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th scl_rise:
    - if byte[7:1]==SLAVE_ADDR and byte[0]==0: go to ADDR_ACK, busy=1.
    - otherwise (address mismatch, or R/W=1, since reads are unsupported): go to IGNORE and NACK by leaving sda released.
  - ADDR_ACK, REG_ACK, DATA_ACK (the ACK slot):
    - On the first scl_fall, drive sda=0.
    - Hold it through the 9th scl_rise.
    - On the next scl_fall, release sda and move to the next state with counter=0.
    - Next states: ADDR_ACK -> REG, REG_ACK -> DATA, DATA_ACK -> DATA.
  - REG: shift 8 bits. On the 8th scl_rise, pointer = byte[REG_AW-1:0] (upper bits ignored), then go to REG_ACK.
  - DATA: shift 8 bits. On the 8th scl_rise:
    - write regfile[pointer]=byte.
    - pulse wr_valid for 1 clk the next cycle, with wr_addr=pointer and wr_data=byte.
    - increment the pointer modulo NUM_REGS (wraps NUM_REGS-1 -> 0).
    - go to DATA_ACK.
  - IGNORE: sda released; ignore all traffic until START or STOP.
- Write latency: wr_valid is asserted 1 clk after the clk where scl_rise for bit 0 (LSB) is detected. rd_data reflects the new value in that same cycle.
- A STOP after a partial data byte (fewer than 8 bits) discards the byte: no write, no wr_valid.
- The ACK is driven only during ACK states. sda is never driven while scl_s is high, except when holding the ACK bit.
- Simultaneous START/STOP detection is impossible (both require an sda edge); START is checked first in code.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_slv_state_t (IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE).
  - constant I2C_WRITE=1'b0.
  - state-code constants shared with the master's encoding.
- One sub-module, i2c_slave_regfile:
  - NUM_REGS x 8, synchronous write, asynchronous read, synchronous active-low clear.
  - Instantiated once.
- Edge detection and the FSM stay in the top module.

Test Plan:
- Write 0x50/W, reg 0x03, data 0xA5, STOP -> three ACKs (sda=0 at 9th scl_rise); a single wr_valid with wr_addr=3, wr_data=0xA5; rd_addr=3 gives 0xA5; busy returns to 0 after STOP.
- Burst: 0x50/W, reg 0x0E, data 0x11, 0x22, 0x33 -> writes regfile[14]=0x11, [15]=0x22, [0]=0x33 (wrap); three wr_valid pulses.
- Address 0x51/W, then 0x50/R -> no ACK (sda stays 1 at the 9th bit); no writes; busy=0; state stays IGNORE until STOP.
- Repeated START after reg 0x05, then 0x50/W, reg 0x07, data 0x5A -> only regfile[7]=0x5A; regfile[5] unchanged.
- STOP after 4 bits of a data byte -> no wr_valid; the register is unchanged; the next full transaction works.
- reset=0 for 1 clk while sda is driven low in REG_ACK -> sda released the next clk; all registers 0; wr_valid=0; the next START is accepted normally.
